reg_dump_reader: RTL and testbench

REG_DUMP_READER -- requirements
Module: reg_dump_reader

---
 rtl/reg_dump_reader.sv | 112 +++++++++++
 tb/tb_reg_dump_reader.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_dump_reader.sv
// Walks a register-file index range two words per beat over dual read ports
// and streams {RD2,RD1} pairs out through a valid/ready handshake.
//
// state | meaning
// IDLE  | waiting for start; start with first>last only pulses err
// READ  | presenting ptr/ptr+1 to the register file, capturing beats
// DRAIN | final beat captured, waiting for it to be accepted
module reg_dump_reader #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [AW-1:0]   first,
  input  logic [AW-1:0]   last,
  output logic [AW-1:0]   A1,
  output logic [AW-1:0]   A2,
  input  logic [DW-1:0]   RD1,
  input  logic [DW-1:0]   RD2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2*DW-1:0] out_data,
  output logic [AW-1:0]   out_addr,
  output logic            out_hi,
  output logic            out_last,
  output logic            busy,
  output logic            done,
  output logic            err
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t            state_q;
  logic [AW:0]       ptr_q;
  logic [AW:0]       end_q;
  logic [AW:0]       ptr_nxt_d;
  logic              capture_d;
  logic              out_valid_q;
  logic [2*DW-1:0]   out_data_q;
  logic [AW-1:0]     out_addr_q;
  logic              out_hi_q;
  logic              out_last_q;
  logic              done_q;
  logic              err_q;

  // One extra pointer bit keeps ptr+1 from wrapping when last is the top index.
  assign ptr_nxt_d = ptr_q + (AW+1)'(1);
  assign capture_d = (state_q == READ) && (!out_valid_q || out_ready);

  assign A1        = (state_q == READ) ? ptr_q[AW-1:0]     : '0;
  assign A2        = (state_q == READ) ? ptr_nxt_d[AW-1:0] : '0;
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_addr  = out_addr_q;
  assign out_hi    = out_hi_q;
  assign out_last  = out_last_q;
  assign done      = done_q;
  assign err       = err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      end_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
      out_hi_q    <= 1'b0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            if (first > last) begin
              err_q <= 1'b1;
            end else begin
              ptr_q   <= {1'b0, first};
              end_q   <= {1'b0, last};
              state_q <= READ;
            end
          end
        end
        READ: begin
          if (capture_d) begin
            out_data_q  <= {RD2, RD1};
            out_addr_q  <= ptr_q[AW-1:0];
            out_hi_q    <= (ptr_nxt_d <= end_q);
            out_last_q  <= (ptr_nxt_d >= end_q);
            out_valid_q <= 1'b1;
            ptr_q       <= ptr_q + (AW+1)'(2);
            if (ptr_nxt_d >= end_q) state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
            done_q      <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_dump_reader.sv
// Directed bench for reg_dump_reader: a behavioural register file answers A1/A2
// and a per-cycle collector records beats, pulses and stall stability.
module tb_reg_dump_reader;

  localparam int DW = 32;
  localparam int AW = 5;

  logic            clk;
  logic            rst;
  logic            start;
  logic [AW-1:0]   first;
  logic [AW-1:0]   last;
  logic [AW-1:0]   A1;
  logic [AW-1:0]   A2;
  logic [DW-1:0]   RD1;
  logic [DW-1:0]   RD2;
  logic            out_valid;
  logic            out_ready;
  logic [2*DW-1:0] out_data;
  logic [AW-1:0]   out_addr;
  logic            out_hi;
  logic            out_last;
  logic            busy;
  logic            done;
  logic            err;

  int tests_run;
  int tests_failed;

  reg_dump_reader #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .first(first), .last(last),
    .A1(A1), .A2(A2), .RD1(RD1), .RD2(RD2),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_addr(out_addr), .out_hi(out_hi), .out_last(out_last),
    .busy(busy), .done(done), .err(err)
  );

  function automatic logic [DW-1:0] rfv(input logic [AW-1:0] a);
    return {16'hCAFE, 3'b000, a, 3'b000, a};
  endfunction

  function automatic logic [2*DW-1:0] pair(input logic [AW-1:0] a);
    logic [AW-1:0] b;
    b = a + 5'd1;
    return {rfv(b), rfv(a)};
  endfunction

  assign RD1 = rfv(A1);
  assign RD2 = rfv(A2);

  logic [84:0] all_outs;
  assign all_outs = {A1, A2, out_valid, out_data, out_addr, out_hi, out_last, busy, done, err};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [AW-1:0]   b_addr [64];
  logic            b_hi   [64];
  logic            b_last [64];
  logic [2*DW-1:0] b_data [64];
  int              b_cyc  [64];
  int              nbeats, done_cnt, done_cyc, err_cnt, err_cyc, first_valid_cyc;
  logic            busy_seen, valid_seen, stable_ok;
  logic [AW-1:0]   a1_c0, a2_c0, ref_a1;
  logic [2*DW-1:0] ref_data;

  task automatic do_start(input logic [AW-1:0] f, input logic [AW-1:0] l);
    @(posedge clk); #1;
    start = 1'b1; first = f; last = l;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Called at posedge+1 of the cycle after the start edge (cycle 0).
  task automatic collect(input int budget, input int stall_idx, input int stall_len,
                         input int poke_cyc);
    int stall_cnt;
    stall_cnt = 0;
    nbeats = 0; done_cnt = 0; done_cyc = -1; err_cnt = 0; err_cyc = -1;
    first_valid_cyc = -1; busy_seen = 0; valid_seen = 0; stable_ok = 1;
    ref_data = '0; ref_a1 = '0; a1_c0 = '0; a2_c0 = '0;
    for (int c = 0; c < budget; c++) begin
      if (c == poke_cyc) begin
        start = 1'b1; first = 5'd9; last = 5'd2;
      end else begin
        start = 1'b0;
      end
      if (out_valid && nbeats == stall_idx && stall_cnt < stall_len) begin
        if (stall_cnt == 0) begin
          ref_data = out_data; ref_a1 = A1;
        end
        out_ready = 1'b0;
        stall_cnt++;
      end else begin
        out_ready = 1'b1;
      end
      @(negedge clk);
      if (c == 0) begin
        a1_c0 = A1; a2_c0 = A2;
      end
      if (out_valid && first_valid_cyc < 0) first_valid_cyc = c;
      if (!out_ready && (out_data !== ref_data || A1 !== ref_a1)) stable_ok = 0;
      if (busy) busy_seen = 1;
      if (out_valid) valid_seen = 1;
      if (err) begin err_cnt++; err_cyc = c; end
      if (done) begin done_cnt++; done_cyc = c; end
      if (out_valid && out_ready && nbeats < 64) begin
        b_addr[nbeats] = out_addr; b_hi[nbeats] = out_hi; b_last[nbeats] = out_last;
        b_data[nbeats] = out_data; b_cyc[nbeats] = c;
        nbeats++;
      end
      @(posedge clk); #1;
      if (done_cnt > 0 && c >= done_cyc + 2) break;
    end
    start = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    #3;
    tests_run++;
    if (all_outs !== '0) begin
      tests_failed++; $display("FAIL reset_async_outs got %h want 0", all_outs);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    tests_run++;
    if (all_outs !== '0) begin
      tests_failed++; $display("FAIL reset_held_outs got %h want 0", all_outs);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++; $display("FAIL reset_release_busy got %b want 0", busy);
    end
  endtask

  task automatic test_full_range;
    do_start(5'd0, 5'd31);
    collect(40, -1, 0, 5);
    tests_run++;
    if (a1_c0 !== 5'd0) begin
      tests_failed++; $display("FAIL full_a1_latency got %0d want 0", a1_c0);
    end
    tests_run++;
    if (first_valid_cyc !== 1) begin
      tests_failed++; $display("FAIL full_valid_latency got %0d want 1", first_valid_cyc);
    end
    tests_run++;
    if (nbeats !== 16) begin
      tests_failed++; $display("FAIL full_beats got %0d want 16", nbeats);
    end
    for (int i = 0; i < 16 && i < nbeats; i++) begin
      logic [AW-1:0] ea;
      ea = AW'(2 * i);
      tests_run++;
      if (b_addr[i] !== ea || b_hi[i] !== 1'b1 || b_last[i] !== (i == 15) ||
          b_data[i] !== pair(ea) || b_cyc[i] !== 1 + i) begin
        tests_failed++;
        $display("FAIL full_beat%0d got addr=%0d hi=%b last=%b data=%h cyc=%0d want addr=%0d hi=1 last=%b data=%h cyc=%0d",
                 i, b_addr[i], b_hi[i], b_last[i], b_data[i], b_cyc[i], ea, (i == 15), pair(ea), 1 + i);
      end
    end
    tests_run++;
    if (done_cnt !== 1 || done_cyc !== 17) begin
      tests_failed++; $display("FAIL full_done got cnt=%0d cyc=%0d want cnt=1 cyc=17", done_cnt, done_cyc);
    end
    tests_run++;
    if (err_cnt !== 0) begin
      tests_failed++; $display("FAIL full_start_ignored_busy got err=%0d want 0", err_cnt);
    end
  endtask

  task automatic test_odd_tail;
    logic [AW-1:0] ea [3];
    logic          eh [3];
    ea[0] = 5'd3; ea[1] = 5'd5; ea[2] = 5'd7;
    eh[0] = 1'b1; eh[1] = 1'b1; eh[2] = 1'b0;
    do_start(5'd3, 5'd7);
    collect(20, -1, 0, -1);
    tests_run++;
    if (nbeats !== 3) begin
      tests_failed++; $display("FAIL odd_beats got %0d want 3", nbeats);
    end
    for (int i = 0; i < 3 && i < nbeats; i++) begin
      tests_run++;
      if (b_addr[i] !== ea[i] || b_hi[i] !== eh[i] || b_last[i] !== (i == 2) ||
          b_data[i] !== pair(ea[i])) begin
        tests_failed++;
        $display("FAIL odd_beat%0d got addr=%0d hi=%b last=%b data=%h want addr=%0d hi=%b last=%b data=%h",
                 i, b_addr[i], b_hi[i], b_last[i], b_data[i], ea[i], eh[i], (i == 2), pair(ea[i]));
      end
    end
    tests_run++;
    if (done_cnt !== 1) begin
      tests_failed++; $display("FAIL odd_done got %0d want 1", done_cnt);
    end
  endtask

  task automatic test_top_index;
    do_start(5'd31, 5'd31);
    collect(20, -1, 0, -1);
    tests_run++;
    if (a1_c0 !== 5'd31 || a2_c0 !== 5'd0) begin
      tests_failed++; $display("FAIL top_addrs got A1=%0d A2=%0d want A1=31 A2=0", a1_c0, a2_c0);
    end
    tests_run++;
    if (nbeats !== 1 || b_addr[0] !== 5'd31 || b_hi[0] !== 1'b0 || b_last[0] !== 1'b1 ||
        b_data[0] !== pair(5'd31)) begin
      tests_failed++;
      $display("FAIL top_beat got n=%0d addr=%0d hi=%b last=%b data=%h want n=1 addr=31 hi=0 last=1 data=%h",
               nbeats, b_addr[0], b_hi[0], b_last[0], b_data[0], pair(5'd31));
    end
    tests_run++;
    if (done_cnt !== 1 || done_cyc !== 2) begin
      tests_failed++; $display("FAIL top_done got cnt=%0d cyc=%0d want cnt=1 cyc=2", done_cnt, done_cyc);
    end
  endtask

  task automatic test_bad_range;
    do_start(5'd9, 5'd2);
    collect(6, -1, 0, -1);
    tests_run++;
    if (err_cnt !== 1 || err_cyc !== 0) begin
      tests_failed++; $display("FAIL bad_err got cnt=%0d cyc=%0d want cnt=1 cyc=0", err_cnt, err_cyc);
    end
    tests_run++;
    if (busy_seen !== 1'b0 || valid_seen !== 1'b0 || done_cnt !== 0) begin
      tests_failed++;
      $display("FAIL bad_quiet got busy=%b valid=%b done=%0d want 0 0 0", busy_seen, valid_seen, done_cnt);
    end
  endtask

  task automatic test_backpressure;
    int ec [4];
    ec[0] = 1; ec[1] = 5; ec[2] = 6; ec[3] = 7;
    do_start(5'd0, 5'd7);
    collect(30, 1, 3, -1);
    tests_run++;
    if (stable_ok !== 1'b1) begin
      tests_failed++; $display("FAIL bp_stable got %b want 1", stable_ok);
    end
    tests_run++;
    if (nbeats !== 4) begin
      tests_failed++; $display("FAIL bp_beats got %0d want 4", nbeats);
    end
    for (int i = 0; i < 4 && i < nbeats; i++) begin
      logic [AW-1:0] ea;
      ea = AW'(2 * i);
      tests_run++;
      if (b_addr[i] !== ea || b_data[i] !== pair(ea) || b_cyc[i] !== ec[i] || b_last[i] !== (i == 3)) begin
        tests_failed++;
        $display("FAIL bp_beat%0d got addr=%0d cyc=%0d last=%b want addr=%0d cyc=%0d last=%b",
                 i, b_addr[i], b_cyc[i], b_last[i], ea, ec[i], (i == 3));
      end
    end
    tests_run++;
    if (done_cnt !== 1 || done_cyc !== 8) begin
      tests_failed++; $display("FAIL bp_done got cnt=%0d cyc=%0d want cnt=1 cyc=8", done_cnt, done_cyc);
    end
  endtask

  task automatic test_reset_mid_dump;
    logic saw_done;
    saw_done = 1'b0;
    do_start(5'd0, 5'd31);
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      if (done) saw_done = 1'b1;
    end
    tests_run++;
    if (out_valid !== 1'b1 || out_addr !== 5'd4) begin
      tests_failed++; $display("FAIL mid_beat3 got valid=%b addr=%0d want 1 4", out_valid, out_addr);
    end
    #2;
    rst = 1'b0;
    #1;
    tests_run++;
    if (all_outs !== '0) begin
      tests_failed++; $display("FAIL mid_reset_outs got %h want 0", all_outs);
    end
    @(posedge clk); #1;
    if (done) saw_done = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    if (done) saw_done = 1'b1;
    tests_run++;
    if (saw_done !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_abort got done=%b busy=%b valid=%b want 0 0 0", saw_done, busy, out_valid);
    end
    do_start(5'd4, 5'd5);
    collect(20, -1, 0, -1);
    tests_run++;
    if (nbeats !== 1 || b_addr[0] !== 5'd4 || b_hi[0] !== 1'b1 || b_last[0] !== 1'b1 ||
        b_data[0] !== pair(5'd4)) begin
      tests_failed++;
      $display("FAIL mid_fresh_beat got n=%0d addr=%0d hi=%b last=%b data=%h want n=1 addr=4 hi=1 last=1 data=%h",
               nbeats, b_addr[0], b_hi[0], b_last[0], b_data[0], pair(5'd4));
    end
    tests_run++;
    if (done_cnt !== 1) begin
      tests_failed++; $display("FAIL mid_fresh_done got %0d want 1", done_cnt);
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    start = 1'b0;
    first = '0;
    last = '0;
    out_ready = 1'b1;
    test_reset();
    test_full_range();
    test_odd_tail();
    test_top_index();
    test_bad_range();
    test_backpressure();
    test_reset_mid_dump();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
